// File: rtl/mult_share_sched.sv
// Round-robin front end for one shared, non-stallable pipelined multiplier.
// Issue is credit-gated so the tagged result FIFO can never overflow.
module mult_share_sched #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 8,
    localparam int IDW    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_y,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [IDW-1:0]            r_last_grant;
    logic [MUL_LAT:0]          r_tag_vld;
    logic [MUL_LAT:0][IDW-1:0] r_tag_id;
    logic [WIDTH-1:0]          r_mul_a;
    logic [WIDTH-1:0]          r_mul_b;
    logic [2*WIDTH-1:0]        r_mem_y [DEPTH];
    logic [IDW-1:0]            r_mem_id [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic                      r_fresh;

    logic [CW-1:0]   w_inflight;
    logic [CW:0]     w_used;
    logic            w_credit_ok;
    logic            w_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [NREQ-1:0] w_gnt_oh;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_rsp_valid;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_tag_vld[i]);
        end
    end

    // A pop in this cycle is deliberately not counted; its credit comes back next cycle.
    assign w_used      = {1'b0, r_count} + {1'b0, w_inflight};
    assign w_credit_ok = (w_used < {1'b0, DEPTH_C});

    always_comb begin : arb
        int idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_gnt_oh = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(r_last_grant) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_found && req_valid[IDW'(idx)]) begin
                w_found  = 1'b1;
                w_gnt_id = IDW'(idx);
            end
        end
        if (w_found) begin
            w_gnt_oh = NREQ'(1) << w_gnt_id;
        end
    end

    assign req_ready = (rst_n && w_credit_ok) ? w_gnt_oh : '0;
    assign w_issue   = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDW'(NREQ - 1);
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[MUL_LAT-1:0], w_issue};
            r_tag_id  <= {r_tag_id[MUL_LAT-1:0], w_gnt_id};
            if (w_issue) begin
                r_last_grant <= w_gnt_id;
                r_mul_a      <= req_a[w_gnt_id*WIDTH +: WIDTH];
                r_mul_b      <= req_b[w_gnt_id*WIDTH +: WIDTH];
            end
        end
    end

    // The newest entry stays hidden for one cycle after its push edge (no bypass).
    assign w_push      = r_tag_vld[MUL_LAT];
    assign w_rsp_valid = r_fresh ? (r_count > CW'(1)) : (r_count != '0);
    assign w_pop       = w_rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_y[r_wr_ptr]  <= mul_y;
            r_mem_id[r_wr_ptr] <= r_tag_id[MUL_LAT];
        end
        if (rst_n && w_push) begin
            assert (r_count != DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fresh  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_fresh <= w_push;
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = w_rsp_valid;
    assign rsp_y     = w_rsp_valid ? r_mem_y[r_rd_ptr] : '0;
    assign rsp_id    = w_rsp_valid ? r_mem_id[r_rd_ptr] : '0;
    assign busy      = (|r_tag_vld) | (r_count != '0);

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a two-stage multiplier model and
// an issue-order scoreboard of expected {product, id}.
module tb_mult_share_sched;
    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int DEPTH   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_y = '0;
    logic [2*WIDTH-1:0]    p1 = '0;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_y;
    logic [1:0]            rsp_id;
    logic                  busy;

    logic [WIDTH-1:0] cur_a [NREQ];
    logic [WIDTH-1:0] cur_b [NREQ];
    bit               auto_m [NREQ];
    logic [15:0]      sb_y [$];
    int               sb_id [$];
    int               gnt_log [$];
    logic [15:0]      pop_y [$];
    int               pop_id [$];
    int               hs_cnt = 0;
    int               pop_cnt = 0;
    int               n_pass = 0;
    int               n_chk = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1    <= (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
        mul_y <= p1;
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = cur_a[i];
            req_b[i*WIDTH +: WIDTH] = cur_b[i];
        end
    end

    mult_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit au);
        cur_a[i]     = a;
        cur_b[i]     = b;
        auto_m[i]    = au;
        req_valid[i] = 1'b1;
    endtask

    // Called at a negedge: sample handshake/pop, cross the edge, update requesters.
    task automatic cyc();
        int hs;
        hs = -1;
        #1;
        chk("onehot_ready", ($countones(req_ready) <= 1), 1);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) hs = i;
        end
        if (hs >= 0) begin
            sb_y.push_back(16'(cur_a[hs]) * 16'(cur_b[hs]));
            sb_id.push_back(hs);
            gnt_log.push_back(hs);
            hs_cnt++;
        end
        if (rsp_valid && rsp_ready) begin
            chk("pop_expected", (sb_y.size() != 0), 1);
            if (sb_y.size() != 0) begin
                chk("rsp_y", rsp_y, sb_y.pop_front());
                chk("rsp_id", rsp_id, sb_id.pop_front());
            end
            pop_y.push_back(rsp_y);
            pop_id.push_back(int'(rsp_id));
            pop_cnt++;
        end
        @(posedge clk);
        #1;
        if (hs >= 0) begin
            if (auto_m[hs]) begin
                cur_a[hs] = WIDTH'($urandom);
                cur_b[hs] = WIDTH'($urandom);
            end else begin
                req_valid[hs] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) auto_m[i] = 1'b0;
        sb_y.delete();
        sb_id.delete();
        gnt_log.delete();
        pop_y.delete();
        pop_id.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) auto_m[i] = 1'b0;
        rsp_ready = 1'b1;
        while ((busy || req_valid != '0 || sb_y.size() != 0) && n < 300) begin
            cyc();
            n++;
        end
        chk({tag, "_drained"}, (n < 300), 1);
        chk({tag, "_sb_empty"}, sb_y.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_y"}, rsp_y, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, base, p0, found;
        for (int i = 0; i < NREQ; i++) begin
            cur_a[i]  = WIDTH'(i + 1);
            cur_b[i]  = WIDTH'(i + 2);
            auto_m[i] = 1'b0;
        end
        req_valid = '1;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset values, with requests pending during reset
        @(negedge clk);
        chk_reset_outputs("rst");
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Single request from requester 2
        rsp_ready = 1'b1;
        set_req(2, 8'd13, 8'd11, 1'b0);
        #1;
        chk("t1_ready_same_cycle", req_ready, 4'b0100);
        cyc();
        chk("t1_busy_high", busy, 1);
        chk("t1_mul_a", mul_a, 13);
        chk("t1_mul_b", mul_b, 11);
        n = 0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("t1_latency", n, 4);
        chk("t1_rsp_y", rsp_y, 143);
        chk("t1_rsp_id", rsp_id, 2);
        cyc();
        chk("t1_busy_low", busy, 0);
        chk("t1_rsp_valid_low", rsp_valid, 0);

        // Fairness: all four continuously requesting
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 8'd255, 8'd255, 1'b1);
        set_req(1, 8'd17, 8'd3, 1'b1);
        set_req(2, 8'd100, 8'd200, 1'b1);
        set_req(3, 8'd7, 8'd9, 1'b1);
        repeat (12) cyc();
        chk("t2_grant_count", gnt_log.size(), 12);
        for (int j = 0; j < 12; j++) begin
            if (j < gnt_log.size()) chk("t2_grant_order", gnt_log[j], j % NREQ);
        end
        drain("t2");
        chk("t2_pop_any", (pop_y.size() != 0), 1);
        if (pop_y.size() != 0) begin
            chk("t2_first_y", pop_y[0], 65025);
            chk("t2_first_id", pop_id[0], 0);
        end

        // Backpressure: exactly DEPTH products buffered, resume after first pop
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        base = hs_cnt;
        repeat (16) cyc();
        chk("t3_hs_count", hs_cnt - base, DEPTH);
        chk("t3_stalled", req_ready, 0);
        chk("t3_full_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #1;
        chk("t3_no_comb_path", req_ready, 0);
        cyc();
        chk("t3_resume_ready", $countones(req_ready), 1);
        base = hs_cnt;
        cyc();
        chk("t3_resume_hs", hs_cnt - base, 1);
        drain("t3");

        // Hold rule: requester 3 waits through a credit stall
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        repeat (DEPTH) cyc();
        set_req(3, 8'd200, 8'd7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_waiting", req_ready[3], 0);
            cyc();
        end
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready[3] && n < 20) begin
            cyc();
            n++;
        end
        chk("t4_granted_within_nreq", (n <= NREQ), 1);
        drain("t4");
        found = 0;
        for (int j = 0; j < pop_id.size(); j++) begin
            if (pop_id[j] == 3) begin
                found++;
                chk("t4_held_product", pop_y[j], 1400);
            end
        end
        chk("t4_found_once", found, 1);

        // Random traffic, 100 transactions, random consumer stalls
        do_reset();
        base = hs_cnt;
        p0   = pop_cnt;
        n    = 0;
        while (hs_cnt - base < 100 && n < 3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
            n++;
        end
        chk("t5_hs_reached", (hs_cnt - base >= 100), 1);
        drain("t5");
        chk("t5_pop_eq_hs", pop_cnt - p0, hs_cnt - base);

        // Mid-operation reset: 3 in flight, 2 in the FIFO
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        repeat (5) cyc();
        chk("t6_busy_pre", busy, 1);
        chk("t6_rsp_valid_pre", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6");
        sb_y.delete();
        sb_id.delete();
        gnt_log.delete();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) auto_m[i] = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        p0        = pop_cnt;
        set_req(0, 8'd10, 8'd10, 1'b0);
        set_req(1, 8'd20, 8'd3, 1'b0);
        set_req(2, 8'd0, 8'd99, 1'b0);
        set_req(3, 8'd128, 8'd2, 1'b0);
        cyc();
        chk("t6_first_grant_any", gnt_log.size(), 1);
        if (gnt_log.size() != 0) chk("t6_first_grant", gnt_log[0], 0);
        drain("t6");
        chk("t6_pop_count", pop_cnt - p0, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
